// File: rtl/skip_pkg.sv
// Shared types and default sizes for the skip_sched mask sequencer.
package skip_pkg;

  localparam int unsigned LEN_DEF     = 16;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned DWELL_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/skip_sched_if.sv
// Control, table-write and ring-drive bundle between the counter logic and skip_sched.
interface skip_sched_if #(
  parameter int LEN     = 16,
  parameter int DEPTH   = 4,
  parameter int DWELL_W = 16
);
  localparam int AW = $clog2(DEPTH);

  logic               WE;
  logic [AW-1:0]      WADDR;
  logic [LEN-1:0]     WMASK;
  logic [DWELL_W-1:0] WDWELL;
  logic               START;
  logic               STOP;
  logic               BUSY;
  logic [AW-1:0]      IDX;
  logic [LEN-1:0]     MASK;
  logic               RING_RST;
  logic               RING_E;
  logic               TICK;
  logic               WRAP;

  modport master (
    output WE, WADDR, WMASK, WDWELL, START, STOP,
    input  BUSY, IDX, MASK, RING_RST, RING_E, TICK, WRAP
  );

  modport slave (
    input  WE, WADDR, WMASK, WDWELL, START, STOP,
    output BUSY, IDX, MASK, RING_RST, RING_E, TICK, WRAP
  );
endinterface

// File: rtl/skip_prescaler.sv
// Divides the system clock into the ring tick; cleared outside RUN.
module skip_prescaler #(
  parameter int unsigned PRE_DIV = 2**24
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr_i,
  input  logic run_nxt_i,
  output logic tick_o,
  output logic tick_nxt_o
);
  localparam int unsigned CW = $clog2(PRE_DIV);
  localparam logic [CW-1:0] TERM = CW'(PRE_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // TICK is registered, so it is predicted from the next count value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || cnt_q == TERM) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    tick_d = run_nxt_i && (cnt_d == TERM);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o     = tick_q;
  assign tick_nxt_o = tick_d;
endmodule

// File: rtl/skip_sched.sv
// Mask/dwell schedule table and LOAD/RUN sequencer driving the skipring.
// Build option SKIP_SCHED_ONESHOT_EN: stop in IDLE after the last entry instead of looping.
//   state | meaning
//   IDLE  | ring held in reset, counters cleared, waiting for START
//   LOAD  | one cycle, new MASK applied while ring still in reset
//   RUN   | ring enabled, counting dwell ticks for the current entry
module skip_sched
  import skip_pkg::*;
#(
  parameter int LEN     = 16,
  parameter int DEPTH   = 4,
  parameter int DWELL_W = 16,
  parameter int PRE_DIV = 2**24
) (
  input logic       CLK,
  input logic       RST,
  skip_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [LEN-1:0]     tbl_mask_q  [DEPTH];
  logic [DWELL_W-1:0] tbl_dwell_q [DEPTH];

  state_e             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [LEN-1:0]     mask_q, mask_d, mask_nxt;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d, dwell_nxt, eff_dwell;
  logic               last_q, last_d, wrap_q, wrap_d;
  logic               busy_q, ring_rst_q, ring_e_q;
  logic               tick, tick_nxt, presc_clr, presc_run_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_mask_q[i]  <= '0;
        tbl_dwell_q[i] <= '0;
      end
    end else if (bus.WE) begin
      tbl_mask_q[bus.WADDR]  <= bus.WMASK;
      tbl_dwell_q[bus.WADDR] <= bus.WDWELL;
    end
  end

  assign presc_clr     = (state_q != RUN);
  assign presc_run_nxt = (state_d == RUN);

  skip_prescaler #(.PRE_DIV(PRE_DIV)) u_presc (
    .CLK        (CLK),
    .RST        (RST),
    .clr_i      (presc_clr),
    .run_nxt_i  (presc_run_nxt),
    .tick_o     (tick),
    .tick_nxt_o (tick_nxt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.START && !bus.STOP) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: state_d = bus.STOP ? IDLE : RUN;
      RUN: begin
        if (bus.STOP) begin
          state_d = IDLE;
        end else if (last_q) begin
          idx_d = idx_q + AW'(1);
`ifdef SKIP_SCHED_ONESHOT_EN
          state_d = (idx_q == AW'(DEPTH - 1)) ? IDLE : LOAD;
`else
          state_d = LOAD;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Table values as they will be after this cycle's write, so the registered
  // MASK and the end-of-entry prediction see same-cycle writes.
  always_comb begin
    mask_nxt  = tbl_mask_q[idx_d];
    dwell_nxt = tbl_dwell_q[idx_d];
    if (bus.WE && bus.WADDR == idx_d) begin
      mask_nxt  = bus.WMASK;
      dwell_nxt = bus.WDWELL;
    end
    eff_dwell   = (dwell_nxt == '0) ? DWELL_W'(1) : dwell_nxt;
    mask_d      = (state_d == LOAD) ? mask_nxt : mask_q;
    dwell_cnt_d = dwell_cnt_q;
    if (state_q != RUN) begin
      dwell_cnt_d = '0;
    end else if (tick) begin
      dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
    end
    // last_q/wrap_q are high during the TICK that completes the entry.
    last_d = tick_nxt &&
             (({1'b0, dwell_cnt_d} + (DWELL_W + 1)'(1)) >= {1'b0, eff_dwell});
    wrap_d = last_d && (idx_q == AW'(DEPTH - 1));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      mask_q      <= '0;
      dwell_cnt_q <= '0;
      last_q      <= 1'b0;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
      ring_rst_q  <= 1'b1;
      ring_e_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      dwell_cnt_q <= dwell_cnt_d;
      last_q      <= last_d;
      wrap_q      <= wrap_d;
      busy_q      <= (state_d != IDLE);
      ring_rst_q  <= (state_d != RUN);
      ring_e_q    <= (state_d == RUN);
    end
  end

  assign bus.BUSY     = busy_q;
  assign bus.IDX      = idx_q;
  assign bus.MASK     = mask_q;
  assign bus.RING_RST = ring_rst_q;
  assign bus.RING_E   = ring_e_q;
  assign bus.TICK     = tick;
  assign bus.WRAP     = wrap_q;
endmodule

// File: tb/tb_skip_sched.sv
// Scoreboard bench for skip_sched with PRE_DIV=4, DEPTH=4.
module tb_skip_sched;
  localparam int LEN     = 16;
  localparam int DEPTH   = 4;
  localparam int DWELL_W = 16;
  localparam int PRE_DIV = 4;

  typedef struct {
    logic [15:0] mask;
    int          idx;
    int          len;
    int          ticks;
    int          wraps;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t sb_q[$];
  exp_t cur_exp;
  logic has_exp = 1'b0;
  logic in_run = 1'b0;
  logic discard = 1'b0;
  logic prev_load = 1'b0;
  int   run_len, tick_cnt, wrap_cnt;

  skip_sched_if #(.LEN(LEN), .DEPTH(DEPTH), .DWELL_W(DWELL_W)) bus ();

  skip_sched #(.LEN(LEN), .DEPTH(DEPTH), .DWELL_W(DWELL_W), .PRE_DIV(PRE_DIV)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void push_e(input logic [15:0] m, input int idx, input int ticks);
    exp_t e;
    e.mask  = m;
    e.idx   = idx;
    e.ticks = ticks;
    e.len   = ticks * PRE_DIV;
    e.wraps = (idx == DEPTH - 1) ? 1 : 0;
    sb_q.push_back(e);
  endfunction

  task automatic finalize();
    exp_t e;
    if (!has_exp || sb_q.size() == 0) begin
      chk("unexpected_entry", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk("entry_idx", cur_exp.idx, e.idx);
      chk("run_len", run_len, e.len);
      chk("run_ticks", tick_cnt, e.ticks);
      chk("run_wraps", wrap_cnt, e.wraps);
    end
    has_exp = 1'b0;
  endtask

  // Monitor: samples mid-cycle, delimits entries by LOAD cycles.
  always @(negedge clk) begin
    if (rst) begin
      in_run    = 1'b0;
      discard   = 1'b0;
      prev_load = 1'b0;
      has_exp   = 1'b0;
    end else if (bus.BUSY && bus.RING_RST) begin
      chk("load_single_cycle", prev_load, 0);
      chk("load_ring_e", bus.RING_E, 0);
      chk("load_tick", bus.TICK, 0);
      if (in_run) begin
        if (discard) begin
          discard = 1'b0;
          has_exp = 1'b0;
        end else begin
          finalize();
        end
      end
      in_run    = 1'b0;
      prev_load = 1'b1;
      run_len   = 0;
      tick_cnt  = 0;
      wrap_cnt  = 0;
      has_exp   = (sb_q.size() > 0);
      if (has_exp) begin
        cur_exp = sb_q[0];
        chk("load_mask", bus.MASK, cur_exp.mask);
        chk("load_idx", bus.IDX, cur_exp.idx);
      end
    end else if (bus.RING_E) begin
      chk("run_ring_rst", bus.RING_RST, 0);
      chk("run_busy", bus.BUSY, 1);
      if (has_exp) chk("run_mask", bus.MASK, cur_exp.mask);
      in_run    = 1'b1;
      prev_load = 1'b0;
      run_len++;
      if (bus.TICK) tick_cnt++;
      if (bus.WRAP) begin
        wrap_cnt++;
        chk("wrap_with_tick", bus.TICK, 1);
      end
    end else begin
      chk("idle_tick", bus.TICK, 0);
      chk("idle_wrap", bus.WRAP, 0);
      chk("idle_ring_rst", bus.RING_RST, 1);
      chk("idle_busy", bus.BUSY, 0);
      prev_load = 1'b0;
      if (in_run) begin
        if (discard) begin
          discard = 1'b0;
          has_exp = 1'b0;
        end else begin
          finalize();
        end
      end
      in_run = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] m, input logic [15:0] d);
    bus.WE     = 1'b1;
    bus.WADDR  = 2'(a);
    bus.WMASK  = m;
    bus.WDWELL = d;
    cyc();
    bus.WE = 1'b0;
  endtask

  task automatic start_pulse();
    bus.START = 1'b1;
    cyc();
    bus.START = 1'b0;
  endtask

  task automatic wait_sb(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("sb_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic wait_run(input int budget);
    int n = 0;
    while (!bus.RING_E && n < budget) begin
      cyc();
      n++;
    end
    chk("wait_run_timeout", bus.RING_E, 1);
  endtask

  task automatic stop_discard();
    discard  = 1'b1;
    bus.STOP = 1'b1;
    cyc();
    bus.STOP = 1'b0;
    chk("stop_busy", bus.BUSY, 0);
    chk("stop_ring_e", bus.RING_E, 0);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_busy"}, bus.BUSY, 0);
    chk({tag, "_ring_rst"}, bus.RING_RST, 1);
    chk({tag, "_ring_e"}, bus.RING_E, 0);
    chk({tag, "_tick"}, bus.TICK, 0);
    chk({tag, "_wrap"}, bus.WRAP, 0);
    chk({tag, "_idx"}, bus.IDX, 0);
    chk({tag, "_mask"}, bus.MASK, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int ticks;
    bus.WE = 1'b0; bus.WADDR = '0; bus.WMASK = '0; bus.WDWELL = '0;
    bus.START = 1'b0; bus.STOP = 1'b0;

    // Reset values
    repeat (3) cyc();
    reset_outputs("rst");
    rst = 1'b0;
    cyc();

    // Programmed sequence
    wr(0, 16'h3445, 16'd2);
    wr(1, 16'h00FF, 16'd1);
    wr(2, 16'hAAAA, 16'd3);
    wr(3, 16'h0001, 16'd1);
    push_e(16'h3445, 0, 2);
    push_e(16'h00FF, 1, 1);
    push_e(16'hAAAA, 2, 3);
    push_e(16'h0001, 3, 1);
`ifndef SKIP_SCHED_ONESHOT_EN
    push_e(16'h3445, 0, 2);
`endif
    start_pulse();
    chk("start_load_idx", bus.IDX, 0);
    chk("start_load_ring_rst", bus.RING_RST, 1);
    wait_sb(200);
`ifndef SKIP_SCHED_ONESHOT_EN
    stop_discard();
`else
    cyc();
    chk("oneshot_idle_busy", bus.BUSY, 0);
`endif
    repeat (2) cyc();

    // STOP and START together during RUN
    start_pulse();
    wait_run(10);
    repeat (2) cyc();
    discard   = 1'b1;
    bus.STOP  = 1'b1;
    bus.START = 1'b1;
    cyc();
    bus.STOP  = 1'b0;
    bus.START = 1'b0;
    chk("stopstart_busy", bus.BUSY, 0);
    chk("stopstart_ring_e", bus.RING_E, 0);
    chk("stopstart_ring_rst", bus.RING_RST, 1);
    cyc();
    chk("stopstart_stays_idle", bus.BUSY, 0);
    push_e(16'h3445, 0, 2);
    start_pulse();
    chk("restart_idx", bus.IDX, 0);
    wait_sb(100);
    stop_discard();
    repeat (2) cyc();

    // Live rewrite of the active entry
    push_e(16'h3445, 0, 2);
    push_e(16'h00FF, 1, 1);
    push_e(16'hAAAA, 2, 2);
    push_e(16'h0001, 3, 1);
`ifndef SKIP_SCHED_ONESHOT_EN
    push_e(16'h5555, 0, 2);
`endif
    start_pulse();
    wait_run(10);
    wr(0, 16'h5555, 16'd2);
    n = 0;
    while (!(bus.IDX == 2'd2 && bus.TICK) && n < 100) begin
      cyc();
      n++;
    end
    chk("entry2_first_tick", bus.TICK, 1);
    wr(2, 16'hAAAA, 16'd0);
    wait_sb(200);
`ifndef SKIP_SCHED_ONESHOT_EN
    stop_discard();
`else
    cyc();
`endif
    repeat (2) cyc();

    // Reset mid-RUN clears outputs and table
    start_pulse();
    wait_run(10);
    cyc();
    rst = 1'b1;
    #1;
    reset_outputs("midrun_rst");
    cyc();
    rst = 1'b0;
    cyc();
    for (int i = 0; i < DEPTH; i++) push_e(16'h0000, i, 1);
`ifndef SKIP_SCHED_ONESHOT_EN
    push_e(16'h0000, 0, 1);
`endif
    start_pulse();
    wait_sb(200);
`ifndef SKIP_SCHED_ONESHOT_EN
    stop_discard();
`else
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (bus.TICK) ticks++;
    end
    chk("oneshot_idx", bus.IDX, 0);
    chk("oneshot_ring_rst", bus.RING_RST, 1);
    chk("oneshot_busy", bus.BUSY, 0);
    chk("oneshot_no_ticks", ticks, 0);
`endif
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
